pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the five-stage MIPS core. It generates the per-stage hold (`bbl`) vector consumed by the PC, if_id, id_ex, ex_mem and mem_wb registers. It arbitrates three stall sources by priority: memory wait, multi-cycle divide and load-use hazard. It also keeps a branch decision that resolves while the PC is frozen, so the redirect is never lost, and provides a stall-cycle counter plus a divide watchdog.

## Interface
Parameters:
- `DIV_MAX`, 64: divide-wait cycles before `div_timeout_o` asserts.
- `CNT_W`, 32: width of the stall performance counter.

Ports:
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  synchronous, active-high (`RstEnable` = 1'b1).
- `stallreq_id_i`  in  1  load-use hazard detected in ID (combinational from ID).
- `div_start_i`  in  1  EX issuing a divide this cycle.
- `div_done_i`  in  1  divider result valid (one-cycle pulse).
- `mem_req_i`  in  1  MEM stage has an outstanding data access.
- `mem_ack_i`  in  1  data memory completes the access this cycle.
- `branch_flag_i`  in  1  ID resolved a taken branch.
- `branch_target_i`  in  `InstAddrBus`  branch target.
- `bbl_o`  out  5  hold vector: bit0 PC, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb. `BblEnable` = hold, `BblDisable` = update.
- `branch_flag_o`  out  1  redirect to the PC register.
- `branch_target_o`  out  `InstAddrBus`  redirect address.
- `div_timeout_o`  out  1  sticky watchdog error.
- `stall_cnt_o`  out  `CNT_W`  count of cycles with `bbl_o[0]` asserted.

## Operation
- State register with states RUN, DIV_WAIT and MEM_WAIT. `bbl_o` is Mealy: it is decoded from the state and the current requests in the same cycle.
- Source priority is mem > div > load-use.
  - mem (`mem_req_i && !mem_ack_i`): `bbl_o = 5'b01111`.
  - div: `bbl_o = 5'b00111`.
  - load-use: `bbl_o = 5'b00011`.
  - none: `bbl_o = 5'b00000`.
- Bubble rule: a stage whose upstream neighbour is held while the stage itself is not held loads a NOP. The stage registers implement this; this block only guarantees the hold vector is contiguous from bit0.
- RUN:
  - `mem_req_i && !mem_ack_i` → MEM_WAIT.
  - else `div_start_i` → DIV_WAIT, and the divide counter clears to 0.
  - else stay in RUN. A load-use hold is combinational only.
- MEM_WAIT:
  - hold 01111 until `mem_ack_i`. The ack cycle outputs the lower-priority vector.
  - On the ack, return to DIV_WAIT if a divide is still pending (pending flag set), else RUN.
- DIV_WAIT:
  - hold 00111, and the counter increments each cycle.
  - `div_done_i` → RUN; the done cycle itself outputs 00000 unless mem stalls.
  - If the counter reaches `DIV_MAX`, set `div_timeout_o` (sticky) and force RUN.
  - A mem stall during DIV_WAIT → MEM_WAIT, with the pending flag set.
- Branch keep:
  - If `branch_flag_i` arrives while `bbl_o[0]` is asserted, latch the target into `pend_target` and set `pend_valid`.
  - On the first cycle with `bbl_o[0]` deasserted, drive `branch_flag_o = 1` with the latched target, then clear `pend_valid`.
  - Otherwise `branch_flag_o`/`branch_target_o` pass `branch_flag_i`/`branch_target_i` through.
  - A live `branch_flag_i` in the release cycle overrides the latched one. The newest decision wins.
- `stall_cnt_o` saturates at all-ones. It does not wrap.

## Timing
- Reset values:
  - `bbl_o` = 0; state RUN.
  - `branch_flag_o` = 0; `branch_target_o` = `ZeroWord`.
  - `div_timeout_o` = 0; `stall_cnt_o` = 0.
  - `pend_valid` = 0; divide counter 0.
- Hold latency is zero cycles: a request in cycle T holds the stages at the edge ending T.
- State change takes effect in cycle T+1.
- Load-use produces exactly one held cycle per asserted cycle of `stallreq_id_i`.
- Divide: `div_start_i` at T gives holds on T+1 … until `div_done_i` (inclusive of done: no); N divide cycles give N held cycles.
- Simultaneous `mem_ack_i` and `div_done_i` in MEM_WAIT go to RUN.
- Reset mid-stall returns everything to reset values at the next edge and drops any pending branch.

## Structure
- `defines.v` holds:
  - `RstEnable`, `BblEnable`/`BblDisable` and `InstAddrBus`.
  - the state encodings `CtrlRun`, `CtrlDivWait` and `CtrlMemWait`.
  - the stage index constants `StgPc` … `StgMemWb`.
- One sub-module, `sat_counter`, with parameter width W, enable and synchronous clear. It is instantiated twice: once for the divide watchdog and once for the stall counter.

## Test plan
- Load-use: pulse `stallreq_id_i` for 1 cycle → `bbl_o` = 00011 for exactly 1 cycle, then 00000; `stall_cnt_o` = 1.
- Divide: `div_start_i` at T, `div_done_i` at T+34 → `bbl_o` = 00111 for T+1…T+33, then 00000 at T+34; no timeout.
- Watchdog: `DIV_MAX` = 8, `div_start_i` with no done → `div_timeout_o` = 1 after 8 held cycles; state RUN; flag stays set until `rst`.
- Priority: `mem_req_i` held 3 cycles without ack while in DIV_WAIT → `bbl_o` = 01111; after `mem_ack_i` → 00111 until `div_done_i`.
- Branch keep: `branch_flag_i` = 1, target 0x0040_0100, during an 00011 hold → `branch_flag_o` = 0 that cycle; next unheld cycle `branch_flag_o` = 1, target 0x0040_0100, for exactly one cycle.
- Reset mid-DIV_WAIT with a pending branch → next cycle all outputs 0; no redirect is ever issued.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants, state encoding and hold-vector helpers
// for the pipeline sequencer.
//   RstEnable            active level of the synchronous reset
//   BblEnable/BblDisable hold / update encoding of one bbl bit
//   InstAddrBus          instruction address width
//   Stg*                 bit index of each pipeline register in bbl
//   ctrl_state_t         sequencer state encoding
package pipe_ctrl_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic BblEnable  = 1'b1;
    localparam logic BblDisable = 1'b0;

    localparam int InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;

    localparam int StgPc    = 0;
    localparam int StgIfId  = 1;
    localparam int StgIdEx  = 2;
    localparam int StgExMem = 3;
    localparam int StgMemWb = 4;
    localparam int StgCount = StgMemWb + 1;

    typedef enum logic [1:0] {
        CtrlRun     = 2'd0,
        CtrlDivWait = 2'd1,
        CtrlMemWait = 2'd2
    } ctrl_state_t;

    // Holds every stage from the PC up to and including stg, so the vector
    // is always contiguous from bit 0 and the first unheld stage bubbles.
    function automatic logic [StgCount-1:0] hold_upto(input int stg);
        logic [StgCount-1:0] v;
        for (int i = 0; i < StgCount; i++) begin
            v[i] = (i <= stg) ? BblEnable : BblDisable;
        end
        return v;
    endfunction

    localparam logic [StgCount-1:0] BblNone    = '0;
    localparam logic [StgCount-1:0] BblLoadUse = hold_upto(StgIfId);
    localparam logic [StgCount-1:0] BblDiv     = hold_upto(StgIdEx);
    localparam logic [StgCount-1:0] BblMem     = hold_upto(StgExMem);

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk    clock
//   rst    synchronous reset, active level RstEnable
//   clr    synchronous clear (lower priority than rst)
//   en     count enable
//   count  current value
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the five-stage core.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   CtrlRun      | no multi-cycle stall; load-use holds are combinational
//   CtrlDivWait  | divide in flight, PC..id_ex held, watchdog counting
//   CtrlMemWait  | data access outstanding, PC..ex_mem held until ack
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallreq_id_i            load-use hazard from ID
//   div_start_i/div_done_i   divide issue / result-valid pulse
//   mem_req_i/mem_ack_i      data access outstanding / completing
//   branch_flag_i/_target_i  taken branch resolved in ID
//   bbl_o                    per-stage hold vector (bit0 PC .. bit4 mem_wb)
//   branch_flag_o/_target_o  redirect to the PC, replayed if it hit a hold
//   div_timeout_o            sticky divide watchdog error
//   stall_cnt_o              saturating count of cycles with the PC held
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_MAX = 64,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_id_i,
    input  logic                   div_start_i,
    input  logic                   div_done_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic [StgCount-1:0]    bbl_o,
    output logic                   branch_flag_o,
    output logic [InstAddrBus-1:0] branch_target_o,
    output logic                   div_timeout_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    localparam int DIV_W = $clog2(DIV_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

    ctrl_state_t state, state_nxt;

    logic                   in_rst;
    logic                   pend_div, pend_div_nxt;
    logic                   mem_stall, mem_hold, div_hold;
    logic                   timeout_hit;
    logic                   div_clr, div_en;
    logic [DIV_W-1:0]       div_cnt;
    logic                   held;
    logic                   pend_valid;
    logic [InstAddrBus-1:0] pend_target;

    assign in_rst = (rst == RstEnable);

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state    <= CtrlRun;
            pend_div <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_div <= pend_div_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pend_div_nxt = 1'b0;
        div_clr      = 1'b0;
        bbl_o        = BblNone;

        mem_stall = mem_req_i && !mem_ack_i;
        // Once in MEM_WAIT only the ack releases the hold.
        mem_hold  = mem_stall || ((state == CtrlMemWait) && !mem_ack_i);
        // A divide parked behind a memory stall resumes holding on the ack
        // cycle, so the lower-priority vector appears there.
        div_hold  = !div_done_i &&
                    ((state == CtrlDivWait) || ((state == CtrlMemWait) && pend_div));
        // div_cnt is the number of DIV_WAIT cycles already completed; >=
        // also catches a count that reached the limit during a mem stall.
        timeout_hit = (state == CtrlDivWait) && !div_done_i && !mem_stall &&
                      (div_cnt >= DIV_LAST);

        case (state)
            CtrlRun: begin
                if (mem_stall) begin
                    state_nxt = CtrlMemWait;
                end else if (div_start_i) begin
                    state_nxt = CtrlDivWait;
                    div_clr   = 1'b1;
                end
            end
            CtrlDivWait: begin
                if (mem_stall) begin
                    state_nxt    = CtrlMemWait;
                    pend_div_nxt = !div_done_i;
                end else if (div_done_i || timeout_hit) begin
                    state_nxt = CtrlRun;
                end
            end
            CtrlMemWait: begin
                if (mem_ack_i) begin
                    state_nxt = (pend_div && !div_done_i) ? CtrlDivWait : CtrlRun;
                end else begin
                    pend_div_nxt = pend_div && !div_done_i;
                end
            end
            default: begin
                state_nxt = CtrlRun;
            end
        endcase

        if (in_rst) begin
            bbl_o = BblNone;
        end else if (mem_hold) begin
            bbl_o = BblMem;
        end else if (div_hold) begin
            bbl_o = BblDiv;
        end else if (stallreq_id_i) begin
            bbl_o = BblLoadUse;
        end
    end

    assign div_en = (state == CtrlDivWait);
    assign held   = (bbl_o[StgPc] == BblEnable);

    sat_counter #(.W(DIV_W)) u_div_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (div_clr),
        .en    (div_en),
        .count (div_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (held),
        .count (stall_cnt_o)
    );

    always_ff @(posedge clk) begin
        if (in_rst) begin
            div_timeout_o <= 1'b0;
        end else if (timeout_hit) begin
            div_timeout_o <= 1'b1;
        end
    end

    // A branch resolved while the PC is frozen would be lost; keep the
    // newest one and replay it on the first cycle the PC can load.
    always_ff @(posedge clk) begin
        if (in_rst) begin
            pend_valid  <= 1'b0;
            pend_target <= ZeroWord;
        end else if (held) begin
            if (branch_flag_i) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target_i;
            end
        end else begin
            pend_valid <= 1'b0;
        end
    end

    always_comb begin
        branch_flag_o   = 1'b0;
        branch_target_o = branch_target_i;
        if (in_rst) begin
            branch_target_o = ZeroWord;
        end else if (!held) begin
            if (branch_flag_i) begin
                branch_flag_o = 1'b1;
            end else if (pend_valid) begin
                branch_flag_o   = 1'b1;
                branch_target_o = pend_target;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int DIV_MAX = 40;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        r_rst, r_sid, r_ds, r_dd, r_mr, r_ma, r_bf;
    logic [31:0] r_bt;
    logic [4:0]  bbl_o;
    logic        branch_flag_o;
    logic [31:0] branch_target_o;
    logic        div_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int vectors = 0;
    int errs    = 0;

    // Reference model state, expressed in terms of outstanding work rather
    // than controller states.
    bit          m_mem;     // data access still outstanding
    bit          m_div;     // divide issued and not finished
    int          m_waited;  // cycles the divide has spent actively waiting
    bit          m_tmo;
    int          m_cnt;
    bit          m_pv;
    logic [31:0] m_pt;

    pipe_ctrl #(.DIV_MAX(DIV_MAX), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (r_rst),
        .stallreq_id_i   (r_sid),
        .div_start_i     (r_ds),
        .div_done_i      (r_dd),
        .mem_req_i       (r_mr),
        .mem_ack_i       (r_ma),
        .branch_flag_i   (r_bf),
        .branch_target_i (r_bt),
        .bbl_o           (bbl_o),
        .branch_flag_o   (branch_flag_o),
        .branch_target_o (branch_target_o),
        .div_timeout_o   (div_timeout_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic sid, input logic ds, input logic dd,
                         input logic mr, input logic ma, input logic bf,
                         input logic [31:0] bt);
        r_rst = rs; r_sid = sid; r_ds = ds; r_dd = dd;
        r_mr = mr; r_ma = ma; r_bf = bf; r_bt = bt;
    endtask

    // One clock: check outputs at the falling edge against the model, then
    // advance the model across the rising edge.
    task automatic cyc();
        bit          mem_hold, div_hold, held;
        int          depth;
        logic [4:0]  eb;
        logic        ef;
        logic [31:0] et;
        @(negedge clk);
        mem_hold = (r_mr && !r_ma) || (m_mem && !r_ma);
        div_hold = m_div && !r_dd;
        if (r_rst)         depth = 0;
        else if (mem_hold) depth = 4;
        else if (div_hold) depth = 3;
        else if (r_sid)    depth = 2;
        else               depth = 0;
        eb   = 5'((1 << depth) - 1);
        held = (depth > 0);
        if (r_rst)          begin ef = 1'b0; et = 32'h0; end
        else if (held)      begin ef = 1'b0; et = r_bt;  end
        else if (r_bf)      begin ef = 1'b1; et = r_bt;  end
        else if (m_pv)      begin ef = 1'b1; et = m_pt;  end
        else                begin ef = 1'b0; et = r_bt;  end
        chk("bbl",     32'(bbl_o),           32'(eb));
        chk("br_flag", 32'(branch_flag_o),   32'(ef));
        chk("br_tgt",  branch_target_o,      et);
        chk("timeout", 32'(div_timeout_o),   32'(m_tmo));
        chk("stall",   32'(stall_cnt_o),     32'(m_cnt));
        @(posedge clk);
        if (r_rst) begin
            m_mem = 0; m_div = 0; m_waited = 0; m_tmo = 0;
            m_cnt = 0; m_pv = 0; m_pt = 32'h0;
        end else begin
            if (held && m_cnt < CNT_MAX) m_cnt++;
            if (held) begin
                if (r_bf) begin m_pv = 1; m_pt = r_bt; end
            end else begin
                m_pv = 0;
            end
            if (m_div && r_dd) begin
                m_div = 0;
            end else if (m_div && !m_mem) begin
                m_waited++;
                if (m_waited >= DIV_MAX && !mem_hold) begin
                    m_tmo = 1; m_div = 0;
                end
            end else if (!m_div && !m_mem && r_ds && !mem_hold) begin
                m_div = 1; m_waited = 0;
            end
            m_mem = mem_hold;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
            cyc();
        end
    endtask

    initial begin
        m_mem = 0; m_div = 0; m_waited = 0; m_tmo = 0;
        m_cnt = 0; m_pv = 0; m_pt = 32'h0;

        // reset
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc(); cyc();

        // load-use single pulse
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0); cyc();
        idle(1);
        chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
        idle(2);

        // divide with done 34 cycles after start
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        idle(33);
        drive(0, 0, 0, 1, 0, 0, 0, 32'h0); cyc();
        idle(2);
        chk("div_no_timeout", 32'(div_timeout_o), 32'd0);

        // mem stall over a divide, then ack, then done
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        idle(3);
        repeat (3) begin drive(0, 0, 0, 0, 1, 0, 0, 32'h0); cyc(); end
        drive(0, 0, 0, 0, 1, 1, 0, 32'h0); cyc();
        idle(4);
        drive(0, 0, 0, 1, 0, 0, 0, 32'h0); cyc();
        idle(2);

        // branch during a load-use hold, replayed on release
        drive(0, 1, 0, 0, 0, 0, 1, 32'h0040_0100); cyc();
        idle(3);

        // newest branch wins in the release cycle
        drive(0, 1, 0, 0, 0, 0, 1, 32'h0040_0200); cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0040_0300); cyc();
        idle(2);

        // simultaneous ack and done while parked in MEM_WAIT
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        idle(2);
        repeat (2) begin drive(0, 0, 0, 0, 1, 0, 0, 32'h0); cyc(); end
        drive(0, 0, 0, 1, 1, 1, 0, 32'h0); cyc();
        idle(3);

        // reset in the middle of a divide with a pending branch
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0040_0400); cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0); cyc();
        idle(3);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // watchdog: start with no done
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        idle(DIV_MAX + 4);
        chk("wdog_timeout", 32'(div_timeout_o), 32'd1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 999) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0),
                  $urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
